// File: rtl/rv32i_pkg.sv
// Shared RV32I branch-unit definitions: funct3 branch conditions, flush FSM
// states and the saturating-counter initial value.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } bpu_state_e;

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic int unsigned cnt_init(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry saturating counter: one combinational
// fetch read port and one synchronous resolve/update port.
module bpu_btb
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic            wr_jump,
  input  logic [XLEN-1:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(cnt_init(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic                valid  [ENTRIES];
  logic                jump   [ENTRIES];
  logic [TAG_W-1:0]    tag    [ENTRIES];
  logic [XLEN-1:0]     target [ENTRIES];
  logic [CNT_BITS-1:0] cnt    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic [1:0]       unused_pc_lsb;

  assign rd_idx        = rd_pc[IDX_W+1:2];
  assign rd_tag        = rd_pc[XLEN-1:IDX_W+2];
  assign wr_idx        = wr_pc[IDX_W+1:2];
  assign wr_tag        = wr_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = rd_pc[1:0] ^ wr_pc[1:0];

  assign rd_hit    = valid[rd_idx] && (tag[rd_idx] == rd_tag);
  assign wr_hit    = valid[wr_idx] && (tag[wr_idx] == wr_tag);
  assign rd_taken  = rd_hit && (cnt[rd_idx][CNT_BITS-1] || jump[rd_idx]);
  assign rd_target = target[rd_idx];

  // Counter read-modify-write happens here so the port stays a single write.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        jump[i]   <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        cnt[i]    <= '0;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          target[wr_idx] <= wr_target;
          if (cnt[wr_idx] != CNT_MAX) cnt[wr_idx] <= cnt[wr_idx] + 1'b1;
        end else if (cnt[wr_idx] != '0) begin
          cnt[wr_idx] <= cnt[wr_idx] - 1'b1;
        end
      end else if (wr_taken) begin
        valid[wr_idx]  <= 1'b1;
        jump[wr_idx]   <= wr_jump;
        tag[wr_idx]    <= wr_tag;
        target[wr_idx] <= wr_target;
        cnt[wr_idx]    <= CNT_INIT;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch prediction with execute-side resolution, mispredict
// redirect and a squash sequencer covering the in-flight fetch-to-execute slots.
module branch_predict_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned CNT_BITS    = 2
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic            stall,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            b_type,
  input  logic            op_jal,
  input  logic            op_jalr,
  input  logic [2:0]      funct3,
  input  logic [20:0]     imm21_j,
  input  logic [11:0]     imm12_i_s,
  input  logic [12:0]     imm13_b,
  input  logic [XLEN-1:0] sub_result,
  input  logic            sub_sign,
  input  logic            sub_borrow,
  input  logic [XLEN-1:0] link_reg_in,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_return,
  output logic            squash
);

  localparam int unsigned FC_W = $clog2(PIPE_DEPTH + 1);

  logic [XLEN-1:0] pc_q  [PIPE_DEPTH];
  logic [XLEN-1:0] tgt_q [PIPE_DEPTH];
  logic [XLEN-1:0] ex_pc, ex_pred_target, ex_seq, btb_target;
  logic [XLEN-1:0] jal_target, br_target, jalr_sum, actual_target;
  logic            btb_taken, cond_taken, actual_taken, is_cti, active, mispredict;
  bpu_state_e      state;
  logic [FC_W-1:0] flush_cnt;

  bpu_btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES), .CNT_BITS(CNT_BITS)) u_btb (
    .clk       (clk),
    .rstB      (rstB),
    .rd_pc     (fetch_pc),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (active && is_cti),
    .wr_pc     (ex_pc),
    .wr_taken  (actual_taken),
    .wr_jump   (op_jal || op_jalr),
    .wr_target (actual_target)
  );

  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : fetch_pc + XLEN'(4);

  // The fetch-time predicted target travels with the PC for the target compare.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        pc_q[i]  <= '0;
        tgt_q[i] <= '0;
      end
    end else if (!stall) begin
      pc_q[0]  <= fetch_pc;
      tgt_q[0] <= pred_target;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        pc_q[i]  <= pc_q[i-1];
        tgt_q[i] <= tgt_q[i-1];
      end
    end
  end

  assign ex_pc          = pc_q[PIPE_DEPTH-1];
  assign ex_pred_target = tgt_q[PIPE_DEPTH-1];
  assign ex_seq         = ex_pc + XLEN'(4);

  always_comb begin
    cond_taken = 1'b0;
    case (funct3)
      F3_BEQ:  cond_taken = (sub_result == '0);
      F3_BNE:  cond_taken = (sub_result != '0);
      F3_BLT:  cond_taken = sub_sign;
      F3_BGE:  cond_taken = !sub_sign;
      F3_BLTU: cond_taken = sub_borrow;
      F3_BGEU: cond_taken = !sub_borrow;
      default: cond_taken = 1'b0;
    endcase
  end

  assign jal_target = ex_pc + {{(XLEN-21){imm21_j[20]}}, imm21_j};
  assign br_target  = ex_pc + {{(XLEN-13){imm13_b[12]}}, imm13_b};
  assign jalr_sum   = link_reg_in + {{(XLEN-12){imm12_i_s[11]}}, imm12_i_s};

  always_comb begin
    actual_target = br_target;
    if (op_jalr)     actual_target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (op_jal) actual_target = jal_target;
  end

  assign is_cti       = b_type || op_jal || op_jalr;
  assign actual_taken = op_jal || op_jalr || (b_type && cond_taken);
  assign active       = rstB && ex_valid && !squash && !stall;
  assign mispredict   = (actual_taken != ex_pred_taken) ||
                        (actual_taken && (actual_target != ex_pred_target));
  assign redirect     = active && mispredict;
  assign redirect_pc  = actual_taken ? actual_target : ex_seq;
  assign pc_return    = (op_jal || op_jalr) ? ex_seq : '0;

  // Flush counts only advancing cycles, so a stall cannot unsquash early.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state     <= ST_IDLE;
      squash    <= 1'b0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (redirect) begin
          state     <= ST_FLUSH;
          squash    <= 1'b1;
          flush_cnt <= '0;
        end
        ST_FLUSH: if (!stall) begin
          if (flush_cnt == FC_W'(PIPE_DEPTH - 1)) begin
            state  <= ST_IDLE;
            squash <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          squash <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: mispredict/redirect, counter
// saturation, branch conditions, JAL/JALR, stall and reset-during-flush.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rstB, stall, pred_taken, ex_valid, b_type, op_jal, op_jalr;
  logic        sub_sign, sub_borrow, ex_pred_taken, redirect, squash;
  logic [31:0] fetch_pc, pred_target, sub_result, link_reg_in, redirect_pc, pc_return;
  logic [2:0]  funct3;
  logic [20:0] imm21_j;
  logic [11:0] imm12_i_s;
  logic [12:0] imm13_b;

  int checks = 0;
  int errors = 0;

  logic [2:0]  cv_f3   [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
  logic [31:0] cv_res  [8] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic        cv_sign [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        cv_borr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        cv_exp  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .PIPE_DEPTH(2), .CNT_BITS(2)) dut (
    .clk(clk), .rstB(rstB), .stall(stall), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .ex_valid(ex_valid),
    .b_type(b_type), .op_jal(op_jal), .op_jalr(op_jalr), .funct3(funct3),
    .imm21_j(imm21_j), .imm12_i_s(imm12_i_s), .imm13_b(imm13_b),
    .sub_result(sub_result), .sub_sign(sub_sign), .sub_borrow(sub_borrow),
    .link_reg_in(link_reg_in), .ex_pred_taken(ex_pred_taken), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc_return(pc_return), .squash(squash)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; b_type = 0; op_jal = 0; op_jalr = 0; funct3 = 3'b000;
    imm21_j = '0; imm12_i_s = '0; imm13_b = '0; sub_result = 32'd1;
    sub_sign = 0; sub_borrow = 0; link_reg_in = '0; ex_pred_taken = 0;
  endtask

  task automatic fetch_to_ex(input logic [31:0] pc);
    fetch_pc = pc;
    tick();
    tick();
  endtask

  task automatic wait_flush();
    clear_ex();
    tick();
    tick();
  endtask

  task automatic set_beq(input logic taken, input logic pred);
    ex_valid = 1; b_type = 1; funct3 = 3'b000; imm13_b = 13'h010;
    sub_result = taken ? 32'd0 : 32'd1; ex_pred_taken = pred;
  endtask

  task automatic resolve_beq(input logic taken, input logic pred);
    fetch_to_ex(32'h100);
    set_beq(taken, pred);
    tick();
    wait_flush();
  endtask

  task automatic test_reset();
    rstB = 0; stall = 0; fetch_pc = 32'h100; clear_ex();
    #3;
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL reset_squash got %0h exp 0", squash); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0h exp 0", redirect); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0h exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h exp 00000104", pred_target); end
    checks++; if (pc_return !== 32'h0) begin errors++; $display("FAIL reset_pc_return got %h exp 0", pc_return); end
    @(posedge clk); #1 rstB = 1;
    tick();
  endtask

  task automatic test_beq_mispredict();
    fetch_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_cold_pred got %0h exp 0", pred_taken); end
    tick(); tick();
    set_beq(1, 0); #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %0h exp 1", redirect); end
    checks++; if (redirect_pc !== 32'h110) begin errors++; $display("FAIL beq_redirect_pc got %h exp 00000110", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_rbw_pred got %0h exp 0", pred_taken); end
    tick();
    set_beq(0, 1); #1;
    checks++; if (squash !== 1'b1) begin errors++; $display("FAIL flush_squash1 got %0h exp 1", squash); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect1 got %0h exp 0", redirect); end
    tick();
    checks++; if (squash !== 1'b1) begin errors++; $display("FAIL flush_squash2 got %0h exp 1", squash); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect2 got %0h exp 0", redirect); end
    clear_ex(); tick();
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL flush_end got %0h exp 0", squash); end
  endtask

  task automatic test_beq_predicted();
    fetch_pc = 32'h100; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL refetch_pred got %0h exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h110) begin errors++; $display("FAIL refetch_target got %h exp 00000110", pred_target); end
    tick(); tick();
    set_beq(1, 1); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL predicted_redirect got %0h exp 0", redirect); end
    tick();
    clear_ex();
  endtask

  task automatic test_counter_saturation();
    resolve_beq(1, 1);
    fetch_to_ex(32'h100);
    set_beq(0, 1); #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL nt_redirect got %0h exp 1", redirect); end
    checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL nt_redirect_pc got %h exp 00000104", redirect_pc); end
    tick(); wait_flush(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL cnt2_pred got %0h exp 1", pred_taken); end
    resolve_beq(0, 1); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cnt1_pred got %0h exp 0", pred_taken); end
    resolve_beq(0, 0);
    resolve_beq(0, 0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cnt0_pred got %0h exp 0", pred_taken); end
    resolve_beq(1, 0); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low_pred got %0h exp 0", pred_taken); end
    resolve_beq(1, 0); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL recover_pred got %0h exp 1", pred_taken); end
  endtask

  task automatic test_conditions();
    logic [31:0] pc, exp_pc;
    for (int unsigned i = 0; i < 8; i++) begin
      pc = 32'h2000 + 32'(i * 4);
      exp_pc = cv_exp[i] ? pc + 32'h40 : pc + 32'h4;
      fetch_to_ex(pc);
      ex_valid = 1; b_type = 1; funct3 = cv_f3[i]; imm13_b = 13'h040;
      sub_result = cv_res[i]; sub_sign = cv_sign[i]; sub_borrow = cv_borr[i]; ex_pred_taken = 0;
      #1;
      checks++; if (redirect !== cv_exp[i]) begin errors++; $display("FAIL cond_redirect f3=%b got %0h exp %0h", cv_f3[i], redirect, cv_exp[i]); end
      checks++; if (redirect_pc !== exp_pc) begin errors++; $display("FAIL cond_redirect_pc f3=%b got %h exp %h", cv_f3[i], redirect_pc, exp_pc); end
      tick();
      wait_flush();
    end
    fetch_pc = 32'h2010; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bltu_alloc_pred got %0h exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h2050) begin errors++; $display("FAIL bltu_alloc_target got %h exp 00002050", pred_target); end
    fetch_pc = 32'h2014; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bgeu_no_alloc got %0h exp 0", pred_taken); end
  endtask

  task automatic test_jumps();
    fetch_to_ex(32'h300);
    ex_valid = 1; op_jalr = 1; link_reg_in = 32'h203; imm12_i_s = 12'h000; ex_pred_taken = 0; #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect got %0h exp 1", redirect); end
    checks++; if (redirect_pc !== 32'h202) begin errors++; $display("FAIL jalr_redirect_pc got %h exp 00000202", redirect_pc); end
    checks++; if (pc_return !== 32'h304) begin errors++; $display("FAIL jalr_pc_return got %h exp 00000304", pc_return); end
    tick(); wait_flush();
    fetch_pc = 32'h300; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h202) begin errors++; $display("FAIL jalr_pred got %0h/%h exp 1/00000202", pred_taken, pred_target); end
    tick(); tick();
    ex_valid = 1; op_jalr = 1; link_reg_in = 32'h401; ex_pred_taken = 1; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin errors++; $display("FAIL jalr_tgt_miss got %0h/%h exp 1/00000400", redirect, redirect_pc); end
    tick(); wait_flush();
    fetch_pc = 32'h300; #1;
    checks++; if (pred_target !== 32'h400) begin errors++; $display("FAIL jalr_refresh got %h exp 00000400", pred_target); end
    fetch_to_ex(32'h400);
    ex_valid = 1; op_jal = 1; imm21_j = 21'h1FFFF0; ex_pred_taken = 0; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h3F0) begin errors++; $display("FAIL jal_back got %0h/%h exp 1/000003f0", redirect, redirect_pc); end
    checks++; if (pc_return !== 32'h404) begin errors++; $display("FAIL jal_pc_return got %h exp 00000404", pc_return); end
    tick(); wait_flush();
  endtask

  task automatic test_stall();
    fetch_to_ex(32'h500);
    stall = 1; fetch_pc = 32'h600;
    set_beq(1, 0); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect got %0h exp 0", redirect); end
    tick(); tick();
    fetch_pc = 32'h500; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL stall_no_update got %0h exp 0", pred_taken); end
    stall = 0; #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h510) begin errors++; $display("FAIL stall_release got %0h/%h exp 1/00000510", redirect, redirect_pc); end
    tick(); wait_flush();
  endtask

  task automatic test_reset_flush();
    fetch_to_ex(32'h700);
    set_beq(1, 0);
    tick();
    checks++; if (squash !== 1'b1) begin errors++; $display("FAIL rst_pre_squash got %0h exp 1", squash); end
    #2 rstB = 0;
    #1;
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL rst_async_squash got %0h exp 0", squash); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0h exp 0", redirect); end
    clear_ex();
    @(posedge clk); #1 rstB = 1;
    fetch_pc = 32'h700; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_700 got %0h exp 0", pred_taken); end
    fetch_pc = 32'h2010; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_2010 got %0h exp 0", pred_taken); end
    tick();
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL rst_idle_squash got %0h exp 0", squash); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_beq_predicted();
    test_counter_saturation();
    test_conditions();
    test_jumps();
    test_stall();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
